// File: rtl/apb_slave_mem_ws.sv
// APB4 word-organised memory slave with byte strobes, a fixed number of wait states
// and PSLVERR on misaligned or out-of-window accesses.
module apb_slave_mem_ws #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(NB);
    localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFF) - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0]            WS_L       = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   write_q;
    logic                   err_q;
    logic [MIDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [NB-1:0]          strb_q;
    logic [DATA_WIDTH-1:0]  prdata_q;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]  word_addr;
    logic [MIDX_W-1:0]      idx_d;
    logic                   err_d;
    logic                   setup;
    logic                   mem_we;

    assign word_addr = paddr >> OFF;
    assign idx_d     = word_addr[MIDX_W-1:0];
    assign err_d     = (|(paddr & ALIGN_MASK)) | ({1'b0, word_addr} >= DEPTH_L);
    assign setup     = pselx & ~penable;

    // Completion is combinational so a zero-wait transfer finishes in its first access cycle.
    assign pready  = (state_q == S_ACCESS) & (cnt_q == 4'd0) & pselx & penable;
    assign pslverr = pready & err_q;
    assign prdata  = prdata_q;
    assign mem_we  = pready & write_q & ~err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else if (setup) begin
            // A setup phase seen while already in ACCESS restarts the transfer.
            state_q <= S_ACCESS;
            cnt_q   <= WS_L;
            write_q <= pwrite;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            if (!pwrite) begin
                prdata_q <= err_d ? '0 : mem[idx_d];
            end
        end else if (state_q == S_ACCESS) begin
            if (!pselx) begin
                state_q <= S_IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    // Memory is never reset; writes land on the completion edge only.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule
